// File: rtl/uart_pkg.sv
// Shared definitions for uart_buffered: FSM state encoding and timer width helpers.
// Optional parity support is selected by the UART_PARITY_EN macro in uart_buffered.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    // Bits needed for a down-counter that must hold values 0..max_val.
    function automatic int div_w(input int max_val);
        return $clog2(max_val + 1);
    endfunction

    // Bits needed for the half-bit start offset.
    function automatic int half_div_w(input int div);
        return $clog2(div / 2 + 1);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO. Pointers carry one extra wrap bit;
// a push in the same cycle as an honoured pop is accepted even when full.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_empty,
    output logic             o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_dout    = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

    // Pointer update; both pointers wrap naturally through the extra MSB.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since empty masks the output.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/uart_buffered.sv
// Full-duplex UART with RX/TX FWFT FIFOs and sticky error flags.
// Define UART_PARITY_EN to add one parity bit (even/odd via i_parity_odd) in both directions.
module uart_buffered
    import uart_pkg::*;
#(
    parameter int CLOCK_HZ  = 100,
    parameter int BAUD      = 10,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int RX_DEPTH  = 4,
    parameter int TX_DEPTH  = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_rx,
    output logic                 o_tx,
    input  logic                 i_rd,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    input  logic                 i_wr,
    input  logic [DATA_BITS-1:0] i_tx_data,
    output logic                 o_tx_ready,
    output logic                 o_tx_busy,
    input  logic                 i_parity_odd,
    input  logic                 i_err_clr,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_overrun
);
    localparam int DIV      = CLOCK_HZ / BAUD;
    localparam int TX_CNT_W = div_w(STOP_BITS * DIV - 1);
    localparam int RX_CNT_W = div_w(DIV - 1);
    localparam int BIT_W    = $clog2(DATA_BITS);

    localparam logic [TX_CNT_W-1:0] TX_BIT_CNT  = TX_CNT_W'(DIV - 1);
    localparam logic [TX_CNT_W-1:0] TX_STOP_CNT = TX_CNT_W'(STOP_BITS * DIV - 1);
    localparam logic [RX_CNT_W-1:0] RX_BIT_CNT  = RX_CNT_W'(DIV - 1);
    localparam logic [RX_CNT_W-1:0] RX_HALF_CNT = RX_CNT_W'(DIV / 2);
    localparam logic [BIT_W-1:0]    LAST_BIT    = BIT_W'(DATA_BITS - 1);

    // ---------------- TX path ----------------
    uart_state_e          r_tx_state;
    logic [TX_CNT_W-1:0]  r_tx_cnt;
    logic [BIT_W-1:0]     r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx;
    logic [DATA_BITS-1:0] w_txf_dout;
    logic                 w_txf_empty;
    logic                 w_txf_full;
    logic                 w_tx_load;

    // Load from the FIFO when idle, or at the end of STOP so frames run gap-free.
    assign w_tx_load = !w_txf_empty &&
                       ((r_tx_state == ST_IDLE) || ((r_tx_state == ST_STOP) && (r_tx_cnt == '0)));

    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_wr && !w_txf_full),
        .i_din   (i_tx_data),
        .i_pop   (w_tx_load),
        .o_dout  (w_txf_dout),
        .o_empty (w_txf_empty),
        .o_full  (w_txf_full)
    );

    assign o_tx       = r_tx;
    assign o_tx_ready = !w_txf_full;
    assign o_tx_busy  = !w_txf_empty || (r_tx_state != ST_IDLE);

`ifdef UART_PARITY_EN
    logic r_tx_par;
`endif

    // TX FSM; the line register follows the state one cycle later, giving wr-to-start of two edges.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
`ifdef UART_PARITY_EN
            r_tx_par   <= 1'b0;
`endif
        end else begin
            case (r_tx_state)
                ST_START:  r_tx <= 1'b0;
                ST_DATA:   r_tx <= r_tx_shift[0];
`ifdef UART_PARITY_EN
                ST_PARITY: r_tx <= r_tx_par;
`endif
                default:   r_tx <= 1'b1;
            endcase

            if (w_tx_load) begin
                r_tx_state <= ST_START;
                r_tx_cnt   <= TX_BIT_CNT;
                r_tx_shift <= w_txf_dout;
`ifdef UART_PARITY_EN
                r_tx_par   <= (^w_txf_dout) ^ i_parity_odd;
`endif
            end else if (r_tx_state != ST_IDLE) begin
                if (r_tx_cnt != '0) begin
                    r_tx_cnt <= r_tx_cnt - 1'b1;
                end else begin
                    case (r_tx_state)
                        ST_START: begin
                            r_tx_state <= ST_DATA;
                            r_tx_cnt   <= TX_BIT_CNT;
                            r_tx_bit   <= '0;
                        end
                        ST_DATA: begin
                            r_tx_shift <= {1'b0, r_tx_shift[DATA_BITS-1:1]};
                            r_tx_cnt   <= TX_BIT_CNT;
                            r_tx_bit   <= r_tx_bit + 1'b1;
                            if (r_tx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
                                r_tx_state <= ST_PARITY;
`else
                                r_tx_state <= ST_STOP;
                                r_tx_cnt   <= TX_STOP_CNT;
`endif
                            end
                        end
`ifdef UART_PARITY_EN
                        ST_PARITY: begin
                            r_tx_state <= ST_STOP;
                            r_tx_cnt   <= TX_STOP_CNT;
                        end
`endif
                        default: r_tx_state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    // ---------------- RX path ----------------
    uart_state_e          r_rx_state;
    logic [RX_CNT_W-1:0]  r_rx_cnt;
    logic [BIT_W-1:0]     r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_rx_s1;
    logic                 r_rx_s2;
    logic                 r_rx_prev;
    logic                 r_ferr;
    logic                 r_ovr;
    logic                 w_rx_fall;
    logic                 w_rx_tick;
    logic                 w_stop_smp;
    logic                 w_par_bad;
    logic                 w_rx_push;
    logic                 w_ferr_set;
    logic                 w_perr_set;
    logic                 w_ovr_set;
    logic                 w_rxf_empty;
    logic                 w_rxf_full;

    assign w_rx_fall  = r_rx_prev && !r_rx_s2;
    assign w_rx_tick  = (r_rx_cnt == '0);
    assign w_stop_smp = (r_rx_state == ST_STOP) && w_rx_tick;
    assign w_rx_push  = w_stop_smp && r_rx_s2 && !w_par_bad;
    assign w_ferr_set = w_stop_smp && !r_rx_s2;
    assign w_perr_set = w_stop_smp && r_rx_s2 && w_par_bad;
    // A simultaneous rd frees a slot, so only an unread full FIFO drops the byte.
    assign w_ovr_set  = w_rx_push && w_rxf_full && !i_rd;

    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_rx_push),
        .i_din   (r_rx_shift),
        .i_pop   (i_rd),
        .o_dout  (o_rx_data),
        .o_empty (w_rxf_empty),
        .o_full  (w_rxf_full)
    );

    assign o_rx_valid  = !w_rxf_empty;
    assign o_frame_err = r_ferr;
    assign o_overrun   = r_ovr;

`ifdef UART_PARITY_EN
    logic r_rx_par_bad;
    logic r_perr;
    assign w_par_bad    = r_rx_par_bad;
    assign o_parity_err = r_perr;
`else
    logic w_unused;
    assign w_par_bad    = 1'b0;
    assign o_parity_err = 1'b0;
    assign w_unused     = i_parity_odd ^ w_perr_set;
`endif

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= i_rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    // RX FSM: half-bit offset to the start centre, then one sample every DIV cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_state <= ST_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
`ifdef UART_PARITY_EN
            r_rx_par_bad <= 1'b0;
`endif
        end else if (r_rx_state == ST_IDLE) begin
            if (w_rx_fall) begin
                r_rx_state <= ST_START;
                r_rx_cnt   <= RX_HALF_CNT;
`ifdef UART_PARITY_EN
                r_rx_par_bad <= 1'b0;
`endif
            end
        end else if (!w_rx_tick) begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
        end else begin
            case (r_rx_state)
                ST_START: begin
                    r_rx_state <= r_rx_s2 ? ST_IDLE : ST_DATA;
                    r_rx_cnt   <= RX_BIT_CNT;
                    r_rx_bit   <= '0;
                end
                ST_DATA: begin
                    r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
                    r_rx_cnt   <= RX_BIT_CNT;
                    r_rx_bit   <= r_rx_bit + 1'b1;
                    if (r_rx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
                        r_rx_state <= ST_PARITY;
`else
                        r_rx_state <= ST_STOP;
`endif
                    end
                end
`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    r_rx_par_bad <= r_rx_s2 != ((^r_rx_shift) ^ i_parity_odd);
                    r_rx_state   <= ST_STOP;
                    r_rx_cnt     <= RX_BIT_CNT;
                end
`endif
                default: r_rx_state <= ST_IDLE;
            endcase
        end
    end

    // Sticky error flags; a new error wins over a clear in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
`ifdef UART_PARITY_EN
            r_perr <= 1'b0;
`endif
        end else begin
            r_ferr <= w_ferr_set || (r_ferr && !i_err_clr);
            r_ovr  <= w_ovr_set  || (r_ovr  && !i_err_clr);
`ifdef UART_PARITY_EN
            r_perr <= w_perr_set || (r_perr && !i_err_clr);
`endif
        end
    end

endmodule

// File: tb/tb_uart_buffered.sv
// Self-checking bench for uart_buffered: RX/TX scoreboards, latency, gap-free TX,
// error flags, overrun, glitch rejection and asynchronous reset mid-frame.
module tb_uart_buffered;
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int BITCLK = 10;
    localparam int FRAME  = NBITS * BITCLK;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx = 1'b1;
    logic       rd = 1'b0;
    logic       wr = 1'b0;
    logic       parity_odd = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx;
    logic [7:0] rx_data;
    logic       rx_valid, tx_ready, tx_busy, frame_err, parity_err, overrun;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] rx_exp[$];
    logic [7:0] tx_exp[$];
    bit         mon_en = 1'b1;

    always #5 clk = ~clk;

    uart_buffered #(
        .CLOCK_HZ(100), .BAUD(10), .DATA_BITS(8), .STOP_BITS(1), .RX_DEPTH(4), .TX_DEPTH(4)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx), .o_tx(tx),
        .i_rd(rd), .o_rx_data(rx_data), .o_rx_valid(rx_valid),
        .i_wr(wr), .i_tx_data(tx_data), .o_tx_ready(tx_ready), .o_tx_busy(tx_busy),
        .i_parity_odd(parity_odd), .i_err_clr(err_clr),
        .o_frame_err(frame_err), .o_parity_err(parity_err), .o_overrun(overrun)
    );

    // Drive one serial frame on rx, LSB first, 10 clocks per bit.
    task automatic send_rx_frame(input logic [7:0] b, input logic stop, input logic par_flip);
        @(negedge clk);
        rx = 1'b0;
        repeat (BITCLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BITCLK) @(negedge clk);
        end
`ifdef UART_PARITY_EN
        rx = (^b) ^ parity_odd ^ par_flip;
        repeat (BITCLK) @(negedge clk);
`else
        if (par_flip) rx = 1'b1;
`endif
        rx = stop;
        repeat (BITCLK) @(negedge clk);
        rx = 1'b1;
    endtask

    // Pop every expected RX byte through rd and compare against the scoreboard.
    task automatic rx_drain(input string name);
        int         w;
        logic [7:0] e;
        while (rx_exp.size() > 0) begin
            w = 0;
            while (rx_valid !== 1'b1 && w < 300) begin
                @(negedge clk);
                w++;
            end
            e = rx_exp.pop_front();
            n_cmp++;
            if (rx_valid !== 1'b1 || rx_data !== e) begin
                n_bad++;
                $display("FAIL %s: rx_valid=%b rx_data=%h, required 1/%h", name, rx_valid, rx_data, e);
            end
            rd = 1'b1;
            @(negedge clk);
            rd = 1'b0;
        end
        n_cmp++;
        if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin
            n_bad++;
            $display("FAIL %s_empty: rx_valid=%b rx_data=%h, required 0/00", name, rx_valid, rx_data);
        end
    endtask

    // TX monitor: decodes each frame at mid-bit and checks it against the TX scoreboard.
    initial begin : tx_mon
        logic [7:0] got;
        logic [7:0] e;
        logic       pbit;
        logic       sbit;
        logic       sb0;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                if (!mon_en) begin
                    while (tx !== 1'b1) @(negedge clk);
                end else begin
                    repeat (5) @(negedge clk);
                    sb0 = tx;
                    for (int i = 0; i < 8; i++) begin
                        repeat (BITCLK) @(negedge clk);
                        got[i] = tx;
                    end
                    pbit = 1'b0;
`ifdef UART_PARITY_EN
                    repeat (BITCLK) @(negedge clk);
                    pbit = tx;
`endif
                    repeat (BITCLK) @(negedge clk);
                    sbit = tx;
                    n_cmp++;
                    if (tx_exp.size() == 0) begin
                        n_bad++;
                        $display("FAIL tx_unexpected: got frame %h, required no frame", got);
                    end else begin
                        e = tx_exp.pop_front();
`ifdef UART_PARITY_EN
                        if (got !== e || sbit !== 1'b1 || sb0 !== 1'b0 || pbit !== ((^e) ^ parity_odd)) begin
`else
                        if (got !== e || sbit !== 1'b1 || sb0 !== 1'b0 || pbit !== 1'b0) begin
`endif
                            n_bad++;
                            $display("FAIL tx_frame: start=%b data=%h par=%b stop=%b, required 0/%h/-/1",
                                     sb0, got, pbit, sbit, e);
                        end
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_cmp++;
        if ({tx, rx_valid, rx_data, tx_ready, tx_busy, frame_err, parity_err, overrun} !== {1'b1, 1'b0, 8'h00, 1'b1, 4'b0000}) begin
            n_bad++;
            $display("FAIL reset_state: tx=%b rxv=%b rxd=%h rdy=%b busy=%b fe=%b pe=%b ov=%b, required 1 0 00 1 0 0 0 0",
                     tx, rx_valid, rx_data, tx_ready, tx_busy, frame_err, parity_err, overrun);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (tx !== 1'b1 || rx_valid !== 1'b0 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset: tx=%b rxv=%b rdy=%b busy=%b, required 1 0 1 0", tx, rx_valid, tx_ready, tx_busy);
        end
    endtask

    task automatic test_rx_basic();
        rx_exp.push_back(8'h45);
        send_rx_frame(8'h45, 1'b1, 1'b0);
        rx_drain("rx_basic");
        rx_exp.push_back(8'hA3);
        send_rx_frame(8'hA3, 1'b1, 1'b0);
        rx_drain("rx_second");
    endtask

    task automatic test_tx_basic();
        @(negedge clk);
        wr = 1'b1;
        tx_data = 8'h49;
        tx_exp.push_back(8'h49);
        @(posedge clk);
        #1 wr = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (tx !== 1'b1) begin
            n_bad++;
            $display("FAIL tx_latency_early: tx=%b at edge N+1, required 1", tx);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (tx !== 1'b0 || tx_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL tx_latency: tx=%b busy=%b at edge N+2, required 0 1", tx, tx_busy);
        end
        // Stop bit starts (NBITS-1)*10 clocks after the start bit.
        repeat ((NBITS - 1) * BITCLK + 3) @(posedge clk);
        #1;
        n_cmp++;
        if (tx !== 1'b1 || tx_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL tx_stop_busy: tx=%b busy=%b mid-stop, required 1 1", tx, tx_busy);
        end
        repeat (8) @(posedge clk);
        #1;
        n_cmp++;
        if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL tx_done: tx=%b busy=%b rdy=%b after stop, required 1 0 1", tx, tx_busy, tx_ready);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        wr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tx_data = 8'(i + 1);
            n_cmp++;
            if (tx_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL b2b_ready: tx_ready=%b before push %0d, required 1", tx_ready, i);
            end
            tx_exp.push_back(8'(i + 1));
            @(posedge clk);
            #1;
        end
        wr = 1'b0;
        n_cmp++;
        if (tx_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_full: tx_ready=%b with 4 queued, required 0", tx_ready);
        end
        // Five gap-free frames end 5*FRAME clocks after the first START.
        repeat (5 * FRAME - 8) @(posedge clk);
        #1;
        n_cmp++;
        if (tx_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_busy: tx_busy=%b near last stop, required 1", tx_busy);
        end
        repeat (8) @(posedge clk);
        #1;
        n_cmp++;
        if (tx_busy !== 1'b0 || tx_exp.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_gap: tx_busy=%b pending=%0d after 5 frames, required 0 0", tx_busy, tx_exp.size());
        end
    endtask

    task automatic test_frame_err();
        send_rx_frame(8'hFF, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (frame_err !== 1'b1 || rx_valid !== 1'b0 || parity_err !== 1'b0) begin
            n_bad++;
            $display("FAIL frame_err: fe=%b rxv=%b pe=%b, required 1 0 0", frame_err, rx_valid, parity_err);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_cmp++;
        if (frame_err !== 1'b0) begin
            n_bad++;
            $display("FAIL frame_err_clr: fe=%b, required 0", frame_err);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] vals[5];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 5; i++) begin
            if (i < 4) rx_exp.push_back(vals[i]);
            send_rx_frame(vals[i], 1'b1, 1'b0);
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (overrun !== 1'b1 || frame_err !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun: ov=%b fe=%b, required 1 0", overrun, frame_err);
        end
        rx_drain("overrun_order");
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun_clr: ov=%b, required 0", overrun);
        end
    endtask

    task automatic test_glitch();
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        n_cmp++;
        if (rx_valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0 || parity_err !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch: rxv=%b fe=%b ov=%b pe=%b, required 0 0 0 0", rx_valid, frame_err, overrun, parity_err);
        end
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity();
        int w;
        parity_odd = 1'b0;
        rx_exp.push_back(8'h45);
        send_rx_frame(8'h45, 1'b1, 1'b0);
        rx_drain("parity_good");
        send_rx_frame(8'h45, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (parity_err !== 1'b1 || rx_valid !== 1'b0 || frame_err !== 1'b0) begin
            n_bad++;
            $display("FAIL parity_err: pe=%b rxv=%b fe=%b, required 1 0 0", parity_err, rx_valid, frame_err);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        parity_odd = 1'b1;
        @(negedge clk);
        wr = 1'b1;
        tx_data = 8'h45;
        tx_exp.push_back(8'h45);
        @(negedge clk);
        wr = 1'b0;
        w = 0;
        while (tx_busy !== 1'b0 && w < 400) begin
            @(negedge clk);
            w++;
        end
        repeat (5) @(negedge clk);
        parity_odd = 1'b0;
        n_cmp++;
        if (tx_busy !== 1'b0 || parity_err !== 1'b0) begin
            n_bad++;
            $display("FAIL parity_tx: busy=%b pe=%b, required 0 0", tx_busy, parity_err);
        end
    endtask
`endif

    task automatic test_reset_mid_tx();
        int w;
        w = 0;
        while (tx_busy !== 1'b0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        repeat (10) @(negedge clk);
        mon_en = 1'b0;
        wr = 1'b1;
        tx_data = 8'h5A;
        @(posedge clk);
        #1 wr = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        n_cmp++;
        if (tx !== 1'b0) begin
            n_bad++;
            $display("FAIL pre_reset_tx: tx=%b in bit 0 of 5A, required 0", tx);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || rx_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_tx: tx=%b rdy=%b busy=%b rxv=%b, required 1 1 0 0", tx, tx_ready, tx_busy, rx_valid);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (tx !== 1'b1 || tx_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL post_mid_reset: tx=%b busy=%b, required 1 0", tx, tx_busy);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_rx_basic();
        test_tx_basic();
        test_back_to_back();
        test_frame_err();
        test_overrun();
        test_glitch();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        test_reset_mid_tx();
        n_cmp++;
        if (rx_exp.size() != 0 || tx_exp.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_left: rx=%0d tx=%0d entries, required 0 0", rx_exp.size(), tx_exp.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
